// File: rtl/debugport_regs.sv
// debugport_regs: decodes framed write commands from a received-byte stream
// into a bank of NUM_REGS registers of 8*DATA_BYTES bits each.
// Frame: SYNC_BYTE, ADDR, D[DATA_BYTES-1]..D[0] (MSB first) [, CSUM].
// Optional macro DEBUGPORT_CHECKSUM_EN adds a trailing XOR checksum byte.
module debugport_regs #(
    parameter int unsigned NUM_REGS       = 4,
    parameter int unsigned DATA_BYTES     = 1,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 250000,
    parameter int unsigned TIMEOUT_WIDTH  = 18
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [7:0]                     i_byte,
    input  logic                           i_ready,
    input  logic [7:0]                     i_sel,
    output logic [NUM_REGS*8*DATA_BYTES-1:0] o_regs,
    output logic [7:0]                     o_led,
    output logic                           o_wr_strobe,
    output logic [7:0]                     o_wr_addr,
    output logic [7:0]                     o_err_count,
    output logic                           o_busy
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned CW = 2;
    localparam int unsigned TW = TIMEOUT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
`ifdef DEBUGPORT_CHECKSUM_EN
        ,ST_CSUM = 2'd3
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_bank [NUM_REGS];
    logic [7:0]      r_addr;
    logic [CW-1:0]   r_byte_cnt;
    logic [DW-1:0]   r_shift;
    logic [TW-1:0]   r_tmo_cnt;
    logic [7:0]      r_err_count;
    logic            r_wr_strobe;
    logic [7:0]      r_wr_addr;
`ifdef DEBUGPORT_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            w_commit;
    logic            w_err;
    logic            w_expired;
    logic            w_addr_ok;
    logic [DW-1:0]   w_shift_next;
    logic [DW-1:0]   w_commit_val;

    assign w_addr_ok    = ({1'b0, r_addr} < 9'(NUM_REGS));
    assign w_expired    = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_shift_next = DW'({r_shift, i_byte});

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus commit/error qualification
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_commit_val = w_shift_next;
        case (r_state)
            ST_IDLE: begin
                if (i_ready && (i_byte == SYNC_BYTE)) begin
                    w_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (i_ready) begin
                    w_state_next = ST_DATA;
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                    w_err        = 1'b1;
                end
            end
            ST_DATA: begin
                if (i_ready) begin
                    if (r_byte_cnt == '0) begin
`ifdef DEBUGPORT_CHECKSUM_EN
                        w_state_next = ST_CSUM;
`else
                        w_state_next = ST_IDLE;
                        if (w_addr_ok) begin
                            w_commit = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
`endif
                    end
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                    w_err        = 1'b1;
                end
            end
`ifdef DEBUGPORT_CHECKSUM_EN
            ST_CSUM: begin
                w_commit_val = r_shift;
                if (i_ready) begin
                    w_state_next = ST_IDLE;
                    if ((i_byte == r_csum) && w_addr_ok) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                    w_err        = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: frame assembly, register bank, timeout and error counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_bank[k] <= '0;
            end
            r_addr      <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_tmo_cnt   <= '0;
            r_err_count <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
`ifdef DEBUGPORT_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_addr;
            end
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (w_commit && (r_addr == 8'(k))) begin
                    r_bank[k] <= w_commit_val;
                end
            end
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            // Gap counter restarts on every accepted byte and whenever idle
            if ((r_state == ST_IDLE) || (w_state_next == ST_IDLE) || i_ready) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
            if (i_ready) begin
                case (r_state)
                    ST_ADDR: begin
                        r_addr     <= i_byte;
                        r_byte_cnt <= CW'(DATA_BYTES - 1);
                        r_shift    <= '0;
`ifdef DEBUGPORT_CHECKSUM_EN
                        r_csum     <= i_byte;
`endif
                    end
                    ST_DATA: begin
                        r_shift    <= w_shift_next;
                        r_byte_cnt <= r_byte_cnt - CW'(1);
`ifdef DEBUGPORT_CHECKSUM_EN
                        r_csum     <= r_csum ^ i_byte;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Flatten the bank onto o_regs
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign o_regs[g*DW +: DW] = r_bank[g];
    end

    // LED mux: low byte of the selected register, zero when out of range
    always_comb begin
        o_led = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (i_sel == 8'(k)) begin
                o_led = r_bank[k][7:0];
            end
        end
    end

    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_err_count = r_err_count;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_debugport_regs.sv
// tb_debugport_regs: scoreboard bench for debugport_regs with two instances
// (DATA_BYTES=1 and DATA_BYTES=2) and a shortened timeout.
module tb_debugport_regs;

    localparam int unsigned TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte1, sel1, byte2, sel2;
    logic        rdy1, rdy2;
    logic [31:0] regs1;
    logic [63:0] regs2;
    logic [7:0]  led1, led2, wr_addr1, wr_addr2, err1, err2;
    logic        strobe1, strobe2, busy1, busy2;

    always #5 clk = ~clk;

    debugport_regs #(.NUM_REGS(4), .DATA_BYTES(1), .SYNC_BYTE(8'hA5),
                     .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(18)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_byte(byte1), .i_ready(rdy1), .i_sel(sel1),
        .o_regs(regs1), .o_led(led1), .o_wr_strobe(strobe1), .o_wr_addr(wr_addr1),
        .o_err_count(err1), .o_busy(busy1));

    debugport_regs #(.NUM_REGS(4), .DATA_BYTES(2), .SYNC_BYTE(8'hA5),
                     .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(18)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_byte(byte2), .i_ready(rdy2), .i_sel(sel2),
        .o_regs(regs2), .o_led(led2), .o_wr_strobe(strobe2), .o_wr_addr(wr_addr2),
        .o_err_count(err2), .o_busy(busy2));

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         sb1[$];
    wr_t         sb2[$];
    wr_t         e1, e2;
    logic [7:0]  m1 [4];
    logic [15:0] m2 [4];
    int          m_err1, m_err2;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        prev1 = 1'b0;
    logic        prev2 = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flat1();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = m1[k];
        return v;
    endfunction

    function automatic logic [63:0] flat2();
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = m2[k];
        return v;
    endfunction

    // Scoreboard monitors: every strobe must match the oldest pending write
    always @(negedge clk) begin
        if (!rst && strobe1) begin
            check("strobe_width1", 64'(prev1), 64'(0));
            if (sb1.size() == 0) begin
                check("wr_unexpected1", 64'(1), 64'(0));
            end else begin
                e1 = sb1.pop_front();
                check("wr_addr1", 64'(wr_addr1), e1.addr);
                check("wr_data1", 64'(regs1[e1.addr[1:0]*8 +: 8]), e1.data);
            end
        end
        prev1 = strobe1;
    end

    always @(negedge clk) begin
        if (!rst && strobe2) begin
            check("strobe_width2", 64'(prev2), 64'(0));
            if (sb2.size() == 0) begin
                check("wr_unexpected2", 64'(1), 64'(0));
            end else begin
                e2 = sb2.pop_front();
                check("wr_addr2", 64'(wr_addr2), e2.addr);
                check("wr_data2", 64'(regs2[e2.addr[1:0]*16 +: 16]), e2.data);
            end
        end
        prev2 = strobe2;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive1(input logic [7:0] b);
        byte1 = b;
        rdy1  = 1'b1;
        @(negedge clk);
        rdy1  = 1'b0;
    endtask

    task automatic drive2(input logic [7:0] b);
        byte2 = b;
        rdy2  = 1'b1;
        @(negedge clk);
        rdy2  = 1'b0;
    endtask

    task automatic bump_err1();
        m_err1 = (m_err1 < 255) ? m_err1 + 1 : 255;
    endtask

    task automatic send_frame1(input logic [7:0] addr, input logic [7:0] d, input int gap);
        logic ok;
        ok = (addr < 8'd4);
        if (ok) sb1.push_back('{addr, 64'(d)});
        drive1(8'hA5); idle(gap);
        drive1(addr);  idle(gap);
        drive1(d);
`ifdef DEBUGPORT_CHECKSUM_EN
        idle(gap);
        drive1(addr ^ d);
`endif
        check("strobe_after_frame1", 64'(strobe1), 64'(ok));
        if (ok) m1[addr[1:0]] = d;
        else    bump_err1();
    endtask

    task automatic send_frame2(input logic [7:0] addr, input logic [15:0] d);
        logic ok;
        ok = (addr < 8'd4);
        if (ok) sb2.push_back('{addr, 64'(d)});
        drive2(8'hA5);
        drive2(addr);
        drive2(d[15:8]);
        drive2(d[7:0]);
`ifdef DEBUGPORT_CHECKSUM_EN
        drive2(addr ^ d[15:8] ^ d[7:0]);
`endif
        check("strobe_after_frame2", 64'(strobe2), 64'(ok));
        if (ok) m2[addr[1:0]] = d;
        else    m_err2 = (m_err2 < 255) ? m_err2 + 1 : 255;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m1[k] = '0;
            m2[k] = '0;
        end
        m_err1 = 0;
        m_err2 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; byte1 = '0; byte2 = '0; rdy1 = 1'b0; rdy2 = 1'b0;
        sel1 = 8'd0; sel2 = 8'd0;
        do_reset();

        // Reset state
        check("rst_regs1", 64'(regs1), 64'(0));
        check("rst_regs2", regs2, 64'(0));
        check("rst_err1", 64'(err1), 64'(0));
        check("rst_busy1", 64'(busy1), 64'(0));
        check("rst_strobe1", 64'(strobe1), 64'(0));
        check("rst_wr_addr1", 64'(wr_addr1), 64'(0));

        // Basic write to reg2
        send_frame1(8'h02, 8'h3C, 1);
        sel1 = 8'd2;
        #1;
        check("led_sel2", 64'(led1), 64'h3C);
        check("regs1_a", 64'(regs1), 64'(flat1()));
        check("err1_a", 64'(err1), 64'(m_err1));
        idle(1);
        check("strobe_drop1", 64'(strobe1), 64'(0));
        check("wr_addr_hold1", 64'(wr_addr1), 64'h02);

        // Noise bytes ignored, bad address counts one error
        drive1(8'h11); drive1(8'h22);
        check("noise_busy1", 64'(busy1), 64'(0));
        send_frame1(8'h07, 8'h55, 0);
        check("badaddr_err1", 64'(err1), 64'(m_err1));
        check("badaddr_regs1", 64'(regs1), 64'(flat1()));

        // Timeout after SYNC ADDR: still busy one cycle before expiry
        drive1(8'hA5); drive1(8'h01);
        idle(TMO - 1);
        check("tmo_busy_before", 64'(busy1), 64'(1));
        idle(1);
        bump_err1();
        check("tmo_busy_after", 64'(busy1), 64'(0));
        check("tmo_err1", 64'(err1), 64'(m_err1));
        send_frame1(8'h01, 8'h55, 0);
        check("after_tmo_regs1", 64'(regs1), 64'(flat1()));

        // Byte arriving in the expiry cycle wins
        send_frame1(8'h03, 8'h66, TMO - 1);
        check("expiry_err1", 64'(err1), 64'(m_err1));
        check("expiry_regs1", 64'(regs1), 64'(flat1()));

        // Back-to-back frames
        send_frame1(8'h00, 8'h11, 0);
        send_frame1(8'h01, 8'h22, 0);
        idle(1);
        check("b2b_regs1", 64'(regs1), 64'(flat1()));

`ifdef DEBUGPORT_CHECKSUM_EN
        // Checksum match and mismatch
        send_frame1(8'h03, 8'hAA, 0);
        drive1(8'hA5); drive1(8'h03); drive1(8'hBB); drive1(8'h00);
        bump_err1();
        check("csum_bad_strobe", 64'(strobe1), 64'(0));
        check("csum_err1", 64'(err1), 64'(m_err1));
        check("csum_regs1", 64'(regs1), 64'(flat1()));
`endif

        // Reset mid-frame discards the partial frame
        drive1(8'hA5); drive1(8'h02);
        do_reset();
        drive1(8'h3C);
        idle(2);
        check("midrst_busy1", 64'(busy1), 64'(0));
        check("midrst_err1", 64'(err1), 64'(0));
        check("midrst_regs1", 64'(regs1), 64'(0));

        // Two-byte registers
        send_frame2(8'h00, 16'h1234);
        sel2 = 8'd0;
        #1;
        check("led2_sel0", 64'(led2), 64'h34);
        sel2 = 8'd9;
        #1;
        check("led2_sel9", 64'(led2), 64'h00);
        send_frame2(8'h03, 16'hBEEF);
        send_frame2(8'h05, 16'h0001);
        sel2 = 8'd3;
        #1;
        check("led2_sel3", 64'(led2), 64'hEF);
        check("regs2", regs2, flat2());
        check("err2", 64'(err2), 64'(m_err2));

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_frame1(8'h09, 8'h00, 0);
            if (i == 253) check("err_254", 64'(err1), 64'(m_err1));
        end
        check("err_sat_model", 64'(err1), 64'(m_err1));
        check("err_sat", 64'(err1), 64'd255);
        check("sat_regs1", 64'(regs1), 64'(flat1()));

        idle(3);
        check("sb1_drained", 64'(sb1.size()), 64'(0));
        check("sb2_drained", 64'(sb2.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
